// File: rtl/seq_demux_5to1_3bit.sv
// -----------------------------------------------------------------------------
// seq_demux_5to1_3bit
//
// Registered 5-way, 3-bit demultiplexer. Each accepted symbol on D is stored in
// one of five channels (U, V, W, X, Y). In manual mode the S input selects the
// channel. In auto mode the channel comes from an internal round-robin pointer.
// A channel stays Full until its Ack bit is sampled high. The producer is
// back-pressured through a combinational Ready.
//
// Ports
//   Clock   in   1  rising-edge clock
//   Resetn  in   1  asynchronous active-low reset
//   D       in   3  data symbol
//   S       in   3  manual select: 000..011 -> U..X, 1xx -> Y
//   Auto    in   1  1 = destination from Ptr, 0 = destination from S
//   Valid   in   1  producer offers D this cycle
//   Ready   out  1  destination channel can accept this cycle
//   Ack     in   5  per-channel consume strobe (bit0 = U .. bit4 = Y)
//   U..Y    out  3  registered channel data
//   Full    out  5  per-channel occupancy (same order as Ack)
//   Ptr     out  3  round-robin pointer, 0..4 -> U..Y
// -----------------------------------------------------------------------------
module seq_demux_5to1_3bit (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [2:0] D,
    input  logic [2:0] S,
    input  logic       Auto,
    input  logic       Valid,
    output logic       Ready,
    input  logic [4:0] Ack,
    output logic [2:0] U,
    output logic [2:0] V,
    output logic [2:0] W,
    output logic [2:0] X,
    output logic [2:0] Y,
    output logic [4:0] Full,
    output logic [2:0] Ptr
);

    logic [2:0] data_q [5];
    logic [2:0] data_d [5];
    logic [4:0] full_q;
    logic [4:0] full_d;
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [4:0] dest;      // one-hot destination channel
    logic       accept;

    // Destination decode. Unreachable pointer values 5..7 fold onto Y.
    always_comb begin
        dest = 5'b00000;
        if (Auto) begin
            case (ptr_q)
                3'd0:    dest = 5'b00001;
                3'd1:    dest = 5'b00010;
                3'd2:    dest = 5'b00100;
                3'd3:    dest = 5'b01000;
                default: dest = 5'b10000;
            endcase
        end else begin
            case (S)
                3'b000:  dest = 5'b00001;
                3'b001:  dest = 5'b00010;
                3'b010:  dest = 5'b00100;
                3'b011:  dest = 5'b01000;
                default: dest = 5'b10000;
            endcase
        end
    end

    // A channel being acked in the same cycle counts as free, which keeps
    // full throughput when the consumer drains every cycle.
    assign Ready  = Resetn & (|(dest & (~full_q | Ack)));
    assign accept = Valid & Ready;

    always_comb begin
        full_d = full_q & ~Ack;
        if (accept) begin
            full_d = full_d | dest;
        end
        for (int i = 0; i < 5; i++) begin
            data_d[i] = data_q[i];
            if (accept && dest[i]) begin
                data_d[i] = D;
            end
        end
        ptr_d = ptr_q;
        if (accept && Auto) begin
            // >= also recovers from the unreachable values 5..7
            ptr_d = (ptr_q >= 3'd4) ? 3'd0 : ptr_q + 3'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 5; i++) begin
                data_q[i] <= 3'b000;
            end
            full_q <= 5'b00000;
            ptr_q  <= 3'd0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                data_q[i] <= data_d[i];
            end
            full_q <= full_d;
            ptr_q  <= ptr_d;
        end
    end

    assign U    = data_q[0];
    assign V    = data_q[1];
    assign W    = data_q[2];
    assign X    = data_q[3];
    assign Y    = data_q[4];
    assign Full = full_q;
    assign Ptr  = ptr_q;

endmodule

// File: tb/tb_seq_demux_5to1_3bit.sv
// -----------------------------------------------------------------------------
// Testbench for seq_demux_5to1_3bit. The driver applies directed vectors just
// after each rising edge and queues the hand-computed values expected for that
// cycle; the monitor drains the queue at the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_seq_demux_5to1_3bit;

    logic       Clock;
    logic       Resetn;
    logic [2:0] D;
    logic [2:0] S;
    logic       Auto;
    logic       Valid;
    logic       Ready;
    logic [4:0] Ack;
    logic [2:0] U, V, W, X, Y;
    logic [4:0] Full;
    logic [2:0] Ptr;

    seq_demux_5to1_3bit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .D      (D),
        .S      (S),
        .Auto   (Auto),
        .Valid  (Valid),
        .Ready  (Ready),
        .Ack    (Ack),
        .U      (U),
        .V      (V),
        .W      (W),
        .X      (X),
        .Y      (Y),
        .Full   (Full),
        .Ptr    (Ptr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam int SU = 0, SV = 1, SW = 2, SX = 3, SY = 4, SF = 5, SP = 6, SR = 7;

    typedef struct {
        string      name;
        int         sel;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [4:0] probe(int sel);
        case (sel)
            SU:      return {2'b00, U};
            SV:      return {2'b00, V};
            SW:      return {2'b00, W};
            SX:      return {2'b00, X};
            SY:      return {2'b00, Y};
            SF:      return Full;
            SP:      return {2'b00, Ptr};
            default: return {4'b0000, Ready};
        endcase
    endfunction

    task automatic want(string name, int sel, logic [4:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drive(logic v, logic [2:0] d, logic [2:0] s, logic a, logic [4:0] k);
        Valid = v;
        D     = d;
        S     = s;
        Auto  = a;
        Ack   = k;
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic want_all_zero(string tag);
        want({tag, " U"}, SU, 5'd0);
        want({tag, " V"}, SV, 5'd0);
        want({tag, " W"}, SW, 5'd0);
        want({tag, " X"}, SX, 5'd0);
        want({tag, " Y"}, SY, 5'd0);
        want({tag, " Full"}, SF, 5'd0);
        want({tag, " Ptr"}, SP, 5'd0);
        want({tag, " Ready"}, SR, 5'd0);
    endtask

    // Monitor: compare everything queued for this cycle.
    always @(negedge Clock) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = probe(e.sel);
            n_checks++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %b, expected %b", e.name, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] svals [5];
        svals[0] = 3'b000;
        svals[1] = 3'b001;
        svals[2] = 3'b010;
        svals[3] = 3'b011;
        svals[4] = 3'b101;

        Resetn = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 5'd0);

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        want_all_zero("reset");

        // Manual fill
        next_cycle(); Resetn = 1'b1;
        drive(1'b1, 3'b101, 3'b000, 1'b0, 5'd0);
        want("fill rdy0", SR, 5'd1); want("fill ptr0", SP, 5'd0);
        next_cycle();
        want("fill U", SU, 5'd5); want("fill full1", SF, 5'b00001);
        drive(1'b1, 3'b110, 3'b001, 1'b0, 5'd0); want("fill rdy1", SR, 5'd1);
        next_cycle();
        want("fill V", SV, 5'd6); want("fill full2", SF, 5'b00011);
        drive(1'b1, 3'b011, 3'b010, 1'b0, 5'd0); want("fill rdy2", SR, 5'd1);
        next_cycle();
        want("fill W", SW, 5'd3); want("fill full3", SF, 5'b00111);
        drive(1'b1, 3'b001, 3'b011, 1'b0, 5'd0); want("fill rdy3", SR, 5'd1);
        next_cycle();
        want("fill X", SX, 5'd1); want("fill full4", SF, 5'b01111);
        drive(1'b1, 3'b111, 3'b111, 1'b0, 5'd0); want("fill rdy4", SR, 5'd1);
        next_cycle();
        want("fill Y", SY, 5'd7); want("fill full5", SF, 5'b11111);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            drive(1'b0, 3'd0, svals[i], 1'b0, 5'd0);
            want($sformatf("full rdy S=%b", svals[i]), SR, 5'd0);
            want("fill ptr hold", SP, 5'd0);
        end

        // Round-robin wrap with every channel acked
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            drive(1'b1, 3'(k + 1), 3'd0, 1'b1, 5'b11111);
            want($sformatf("rr rdy %0d", k), SR, 5'd1);
            want($sformatf("rr ptr %0d", k), SP, 5'(k % 5));
        end
        next_cycle();
        drive(1'b0, 3'd0, 3'd0, 1'b1, 5'd0);
        want("rr ptr end", SP, 5'd2);
        want("rr U", SU, 5'd6); want("rr V", SV, 5'd7); want("rr W", SW, 5'd3);
        want("rr X", SX, 5'd4); want("rr Y", SY, 5'd5);
        want("rr full", SF, 5'b00010);

        // Refill everything, leaving Ptr at 0
        next_cycle(); drive(1'b1, 3'b001, 3'd0, 1'b1, 5'd0);
        want("bp fill rdy W", SR, 5'd1); want("bp ptr2", SP, 5'd2);
        next_cycle(); drive(1'b1, 3'b010, 3'd0, 1'b1, 5'd0);
        want("bp W", SW, 5'd1); want("bp ptr3", SP, 5'd3);
        next_cycle(); drive(1'b1, 3'b011, 3'd0, 1'b1, 5'd0);
        want("bp X", SX, 5'd2); want("bp ptr4", SP, 5'd4);
        next_cycle(); drive(1'b1, 3'b100, 3'b000, 1'b0, 5'd0);
        want("bp Y", SY, 5'd3); want("bp ptr wrap", SP, 5'd0);
        want("bp full4", SF, 5'b11110); want("bp rdy man U", SR, 5'd1);

        // Back-pressure
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1'b1, 3'b010, 3'd0, 1'b1, 5'd0);
            want($sformatf("bp stall rdy %0d", i), SR, 5'd0);
            want($sformatf("bp stall ptr %0d", i), SP, 5'd0);
            want($sformatf("bp stall U %0d", i), SU, 5'd4);
        end
        next_cycle(); drive(1'b1, 3'b010, 3'd0, 1'b1, 5'b00001);
        want("bp ack rdy", SR, 5'd1); want("bp ack ptr", SP, 5'd0);
        next_cycle(); drive(1'b0, 3'd0, 3'd0, 1'b0, 5'd0);
        want("bp U", SU, 5'd2); want("bp full", SF, 5'b11111); want("bp ptr1", SP, 5'd1);

        // Simultaneous events in manual mode
        next_cycle(); drive(1'b1, 3'b100, 3'b001, 1'b0, 5'b00010);
        want("sim rdy a", SR, 5'd1);
        next_cycle(); drive(1'b1, 3'b011, 3'b001, 1'b0, 5'b00110);
        want("sim V pre", SV, 5'd4); want("sim full pre", SF, 5'b11111);
        want("sim rdy b", SR, 5'd1);
        next_cycle(); drive(1'b0, 3'd0, 3'b001, 1'b0, 5'b00100);
        want("sim V", SV, 5'd3); want("sim full", SF, 5'b11011);
        want("sim W", SW, 5'd1); want("sim ptr", SP, 5'd1);
        next_cycle(); drive(1'b0, 3'd0, 3'd0, 1'b0, 5'b11111);
        want("ack empty full", SF, 5'b11011); want("ack empty W", SW, 5'd1);

        // Reset mid-operation with Ptr=3
        next_cycle(); drive(1'b1, 3'b101, 3'd0, 1'b1, 5'd0);
        want("mr full0", SF, 5'd0); want("mr ptr1", SP, 5'd1);
        next_cycle(); drive(1'b1, 3'b101, 3'd0, 1'b1, 5'd0);
        want("mr V", SV, 5'd5); want("mr ptr2", SP, 5'd2);
        next_cycle(); drive(1'b0, 3'd0, 3'd0, 1'b1, 5'd0);
        want("mr ptr3", SP, 5'd3); want("mr full", SF, 5'b00110);
        next_cycle(); drive(1'b1, 3'b110, 3'd0, 1'b1, 5'd0);
        #1;
        Resetn = 1'b0;
        want_all_zero("async reset");
        @(negedge Clock);
        #1;
        Resetn = 1'b1;
        next_cycle(); drive(1'b0, 3'd0, 3'd0, 1'b1, 5'd0);
        want("post rst U", SU, 5'd6); want("post rst full", SF, 5'b00001);
        want("post rst ptr", SP, 5'd1); want("post rst V", SV, 5'd0);

        next_cycle();
        @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
